// File: rtl/rssi_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : rssi_frame_packer
// Purpose  : Packs 16-bit RSSI samples into 5-byte UART frames
//            (sync, seq, data MSB, data LSB, checksum) and writes them one
//            byte at a time into the UART transmit FIFO, honouring its
//            full flag. One sample can wait while a frame is in flight;
//            samples that get overwritten are counted as drops.
// Ports    : clk, rst        - core clock, asynchronous active-high reset
//            data_i, valid_i - RSSI sample and its single-cycle qualifier
//            fifo_full_i     - UART FIFO full flag
//            uart_data       - byte to the FIFO (valid while wr_en_o=1)
//            wr_en_o         - one-cycle FIFO write strobe
//            busy_o          - frame in flight or a sample pending
//            drop_cnt_o      - saturating count of discarded samples
// Revision : 1.0 - initial release
// ============================================================================
module rssi_frame_packer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DW        = 16,
  parameter int         DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     data_i,
  input  logic              valid_i,
  input  logic              fifo_full_i,
  output logic [7:0]        uart_data,
  output logic              wr_en_o,
  output logic              busy_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  // The frame carries exactly two data bytes.
  generate
    if (DW != 16) begin : g_dw_check
      $error("rssi_frame_packer: DW must be 16");
    end
  endgenerate

  localparam logic [DROP_W-1:0] c_DROP_MAX = {DROP_W{1'b1}};
  localparam logic [2:0]        c_LAST_IDX = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              state_q,    state_d;
  logic [2:0]          idx_q,      idx_d;
  logic [DW-1:0]       frame_q,    frame_d;
  logic [7:0]          seq_q,      seq_d;
  logic [DW-1:0]       pend_q,     pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DROP_W-1:0]   drop_q,     drop_d;
  logic [7:0]          data_q,     data_d;
  logic                wr_en_q,    wr_en_d;

  logic                w_start;
  logic [DW-1:0]       w_frame;
  logic [2:0]          w_idx;
  logic                w_issue;
  logic                w_last;
  logic [7:0]          w_byte;
  logic [DROP_W-1:0]   w_drop_inc;

  // A sample arriving in IDLE is framed in the same cycle, so B0 can be
  // registered straight away and appear one cycle after valid_i.
  assign w_start = (state_q == ST_IDLE) && valid_i;
  assign w_frame = w_start ? data_i : frame_q;
  assign w_idx   = w_start ? 3'd0 : idx_q;

  // The registered strobe forces an idle cycle after every write so the
  // FIFO full flag has settled before the next byte is committed.
  assign w_issue = (w_start || (state_q == ST_EMIT)) && !fifo_full_i && !wr_en_q;
  assign w_last  = w_issue && (w_idx == c_LAST_IDX);

  assign w_drop_inc = (drop_q == c_DROP_MAX) ? drop_q : drop_q + 1'b1;

  always_comb begin
    w_byte = 8'h00;
    case (w_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = seq_q;
      3'd2:    w_byte = w_frame[15:8];
      3'd3:    w_byte = w_frame[7:0];
      default: w_byte = seq_q + w_frame[15:8] + w_frame[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    seq_d      = seq_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          frame_d = data_i;
          idx_d   = 3'd0;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (w_last) begin
          seq_d = seq_q + 8'd1;
          idx_d = 3'd0;
          if (pend_vld_q) begin
            // Pending sample starts the next frame; a simultaneous new
            // sample takes its place and counts as a drop.
            frame_d = pend_q;
            if (valid_i) begin
              pend_d = data_i;
              drop_d = w_drop_inc;
            end else begin
              pend_vld_d = 1'b0;
            end
          end else if (valid_i) begin
            frame_d = data_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (valid_i) begin
          // Newest sample wins; an overwritten pending sample is a drop.
          pend_d     = data_i;
          pend_vld_d = 1'b1;
          if (pend_vld_q) begin
            drop_d = w_drop_inc;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (w_issue) begin
      wr_en_d = 1'b1;
      data_d  = w_byte;
      if (!w_last) begin
        idx_d = w_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      frame_q    <= '0;
      seq_q      <= 8'd0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= '0;
      data_q     <= 8'd0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      seq_q      <= seq_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign uart_data  = data_q;
  assign wr_en_o    = wr_en_q;
  assign busy_o     = (state_q != ST_IDLE) || pend_vld_q;
  assign drop_cnt_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_rssi_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rssi_frame_packer
// Purpose  : Self-checking bench for rssi_frame_packer. Expected frame bytes
//            are pushed to a queue when samples are driven and compared as
//            the DUT writes them to the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rssi_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic        valid_i;
  logic        fifo_full_i;
  logic [7:0]  uart_data;
  logic        wr_en_o;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq_m = 8'd0;

  rssi_frame_packer #(
    .SYNC_BYTE (8'hA5),
    .DW        (16),
    .DROP_W    (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .fifo_full_i (fifo_full_i),
    .uart_data   (uart_data),
    .wr_en_o     (wr_en_o),
    .busy_o      (busy_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: A5, seq, MSB, LSB, 8-bit sum of the last three.
  task automatic push_frame(input logic [15:0] d);
    logic [7:0] cs;
    cs = seq_m + d[15:8] + d[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq_m);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(cs);
    seq_m = seq_m + 8'd1;
  endtask

  // Drives one valid pulse; returns #1 after the next rising edge.
  task automatic send(input logic [15:0] d, input bit expect_frame);
    data_i  = d;
    valid_i = 1'b1;
    if (expect_frame) push_frame(d);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Counts writes starting with the current cycle; returns in the cycle
  // of the n-th write.
  task automatic wait_writes(input int n);
    int cnt;
    bit ok;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wr_en_o) cnt++;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_writes_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_idle_timeout", {31'd0, ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every FIFO write must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && wr_en_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $error("FAIL unexpected_write: observed %0h expected no write", uart_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        assert (uart_data === e) else begin
          n_errors++;
          $error("FAIL frame_byte: observed %0h expected %0h", uart_data, e);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    data_i      = 16'h0000;
    valid_i     = 1'b0;
    fifo_full_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_uart_data", {24'd0, uart_data}, 32'h00);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt_o}, 32'd0);

    // Basic frame, one-cycle latency, alternating strobe, busy drop
    send(16'h1234, 1'b1);
    chk("latency_wr_en", {31'd0, wr_en_o}, 32'd1);
    chk("latency_sync", {24'd0, uart_data}, 32'hA5);
    chk("busy_in_frame", {31'd0, busy_o}, 32'd1);
    @(posedge clk); #1;
    chk("gap_cycle", {31'd0, wr_en_o}, 32'd0);
    wait_writes(4);
    chk("busy_after_b4", {31'd0, busy_o}, 32'd0);
    wait_idle();

    // Sequence increment and checksum wrap
    send(16'hFFFF, 1'b1);
    wait_idle();

    // Backpressure stall after B1
    send(16'h0001, 1'b1);
    wait_writes(2);
    fifo_full_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall_no_write", {31'd0, wr_en_o}, 32'd0);
    end
    fifo_full_i = 1'b0;
    wait_idle();

    // Three samples in one frame: middle one overwritten
    send(16'h0010, 1'b1);
    send(16'h0020, 1'b0);
    send(16'h0030, 1'b1);
    chk("drop_one", {24'd0, drop_cnt_o}, 32'd1);
    wait_idle();
    chk("drop_one_after", {24'd0, drop_cnt_o}, 32'd1);

    // Asynchronous reset mid-frame (after B2)
    send(16'h5555, 1'b1);
    wait_writes(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("async_rst_data", {24'd0, uart_data}, 32'h00);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("async_rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    exp_q.delete();
    seq_m = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", {31'd0, wr_en_o}, 32'd0);
    send(16'hABCD, 1'b1);
    wait_idle();

    // 256 more frames: the last one carries seq 00 again
    for (int f = 0; f < 255; f++) begin
      send(16'($urandom), 1'b1);
      wait_idle();
    end
    send(16'h4242, 1'b1);
    wait_writes(2);
    chk("seq_wrap", {24'd0, uart_data}, 32'h00);
    wait_idle();

    // 300 drops with the FIFO held full: counter saturates
    fifo_full_i = 1'b1;
    for (int i = 0; i < 302; i++) begin
      data_i  = 16'(i);
      valid_i = 1'b1;
      if (i == 0) push_frame(16'(i));
      @(posedge clk); #1;
      if (i == 255) chk("drop_254", {24'd0, drop_cnt_o}, 32'd254);
    end
    valid_i = 1'b0;
    push_frame(16'd301);
    chk("drop_saturate", {24'd0, drop_cnt_o}, 32'd255);
    chk("busy_pending", {31'd0, busy_o}, 32'd1);
    fifo_full_i = 1'b0;
    wait_idle();
    chk("drop_hold", {24'd0, drop_cnt_o}, 32'd255);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
